// File: rtl/spi_flash_fetcher_pkg.sv
// Register map of the SPI flash reader peripheral (shared with the peripheral)
// and the fetcher state encoding.
`ifndef SPIMEM_REGS_DEFINED
`define SPIMEM_REGS_DEFINED
`define SPIMEM_CONTROL     0
`define SPIMEM_READ_ADDR   1
`define SPIMEM_READ_LENGTH 2
`endif

package spi_flash_fetcher_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_LEN,
    S_WR_CTRL,
    S_POLL_WAIT,
    S_POLL,
    S_RD_WORD,
    S_EMIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/wb_single_master.sv
// Classic Wishbone master: one single read or write per request pulse.
// Requests arriving while a cycle is open are ignored.
module wb_single_master #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     req_we_i,
  input  logic [ADDRESS_WIDTH-1:0] req_adr_i,
  input  logic [DATA_WIDTH-1:0]    req_dat_i,
  output logic [ADDRESS_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0]    dat_o,
  output logic                     we_o,
  output logic                     stb_o,
  output logic                     cyc_o,
  input  logic                     ack_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic                     ack_o,
  output logic [DATA_WIDTH-1:0]    rd_dat_o
);

  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0]    dat_q, dat_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (cyc_q) begin
      if (ack_i) cyc_d = 1'b0;
    end else if (req_i) begin
      cyc_d = 1'b1;
      we_d  = req_we_i;
      adr_d = req_adr_i;
      dat_d = req_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst_i) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign cyc_o    = cyc_q;
  assign stb_o    = cyc_q;
  assign we_o     = we_q;
  assign adr_o    = adr_q;
  assign dat_o    = dat_q;
  assign ack_o    = cyc_q & ack_i;
  assign rd_dat_o = dat_i;

endmodule

// File: rtl/spi_flash_fetcher.sv
// Programs the SPI flash reader, polls it to completion, then streams its
// word buffer out on a valid/ready interface.
module spi_flash_fetcher
  import spi_flash_fetcher_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       DATA_BYTES    = 4,
  parameter logic [ADDRESS_WIDTH-1:0] REG_BASE      = 16'h0000,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_BASE      = 16'h1000,
  parameter int                       POLL_GAP      = 4,
  parameter int                       POLL_LIMIT    = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [15:0]              page_i,
  input  logic [8:0]               length_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [ADDRESS_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0]    dat_o,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic                     we_o,
  output logic [DATA_BYTES-1:0]    sel_o,
  output logic                     stb_o,
  output logic                     cyc_o,
  input  logic                     ack_i,
  output logic [2:0]               cti_o,
  output logic [DATA_WIDTH-1:0]    word_o,
  output logic                     word_valid_o,
  input  logic                     word_ready_i
);

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADR_CTRL  = ADDRESS_WIDTH'(REG_BASE + `SPIMEM_CONTROL);
  localparam logic [ADDRESS_WIDTH-1:0] ADR_RADDR = ADDRESS_WIDTH'(REG_BASE + `SPIMEM_READ_ADDR);
  localparam logic [ADDRESS_WIDTH-1:0] ADR_RLEN  = ADDRESS_WIDTH'(REG_BASE + `SPIMEM_READ_LENGTH);

  state_e                   state_q;
  logic                     busy_q, done_q, error_q, valid_q;
  logic [15:0]              page_q;
  logic [8:0]               len_q, idx_q;
  logic [CNT_W-1:0]         poll_q, poll_inc;
  logic [GAP_W-1:0]         gap_q;
  logic [DATA_WIDTH-1:0]    word_q;
  logic                     pending_q, req_q, req_we_q;
  logic [ADDRESS_WIDTH-1:0] req_adr_q;
  logic [DATA_WIDTH-1:0]    req_dat_q;
  logic                     bus_ack;
  logic [DATA_WIDTH-1:0]    bus_rdat;

  logic                     acc_en, acc_we;
  logic [ADDRESS_WIDTH-1:0] acc_adr;
  logic [DATA_WIDTH-1:0]    acc_dat;

  // Bus access implied by the current state; issued once per state visit.
  always_comb begin
    acc_en  = 1'b0;
    acc_we  = 1'b0;
    acc_adr = '0;
    acc_dat = '0;
    case (state_q)
      S_WR_ADDR: begin
        acc_en = 1'b1; acc_we = 1'b1; acc_adr = ADR_RADDR;
        acc_dat = DATA_WIDTH'({8'h00, page_q, 8'h00});
      end
      S_WR_LEN: begin
        acc_en = 1'b1; acc_we = 1'b1; acc_adr = ADR_RLEN;
        acc_dat = DATA_WIDTH'(len_q);
      end
      S_WR_CTRL: begin
        acc_en = 1'b1; acc_we = 1'b1; acc_adr = ADR_CTRL;
        acc_dat = DATA_WIDTH'(1);
      end
      S_POLL:    begin acc_en = 1'b1; acc_adr = ADR_CTRL; end
      S_RD_WORD: begin acc_en = 1'b1; acc_adr = MEM_BASE + ADDRESS_WIDTH'(idx_q); end
      default: ;
    endcase
  end

  always_comb begin
    poll_inc = (poll_q == '1) ? poll_q : poll_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
      page_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      poll_q    <= '0;
      gap_q     <= '0;
      word_q    <= '0;
      pending_q <= 1'b0;
      req_q     <= 1'b0;
      req_we_q  <= 1'b0;
      req_adr_q <= '0;
      req_dat_q <= '0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      // The request is a registered pulse, so the cycle after each ack is always bus-idle.
      if (acc_en && !pending_q) begin
        req_q     <= 1'b1;
        req_we_q  <= acc_we;
        req_adr_q <= acc_adr;
        req_dat_q <= acc_dat;
        pending_q <= 1'b1;
      end
      if (bus_ack) pending_q <= 1'b0;

      case (state_q)
        S_IDLE: if (start_i) begin
          error_q <= 1'b0;
          if (length_i != '0) begin
            busy_q  <= 1'b1;
            page_q  <= page_i;
            len_q   <= length_i;
            state_q <= S_WR_ADDR;
          end else begin
            done_q <= 1'b1;
          end
        end
        S_WR_ADDR: if (bus_ack) state_q <= S_WR_LEN;
        S_WR_LEN:  if (bus_ack) state_q <= S_WR_CTRL;
        S_WR_CTRL: if (bus_ack) begin
          poll_q  <= '0;
          gap_q   <= '0;
          state_q <= S_POLL_WAIT;
        end
        S_POLL_WAIT: begin
          if (gap_q == GAP_W'(POLL_GAP - 1)) begin
            gap_q   <= '0;
            state_q <= S_POLL;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_POLL: if (bus_ack) begin
          poll_q <= poll_inc;
          if (!bus_rdat[0]) begin
            idx_q   <= '0;
            state_q <= S_RD_WORD;
          end else if (poll_inc < CNT_W'(POLL_LIMIT)) begin
            state_q <= S_POLL_WAIT;
          end else begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RD_WORD: if (bus_ack) begin
          word_q  <= bus_rdat;
          valid_q <= 1'b1;
          state_q <= S_EMIT;
        end
        S_EMIT: if (word_ready_i) begin
          valid_q <= 1'b0;
          if (idx_q == len_q - 9'd1) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + 9'd1;
            state_q <= S_RD_WORD;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  wb_single_master #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_q),
    .req_we_i (req_we_q),
    .req_adr_i(req_adr_q),
    .req_dat_i(req_dat_q),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .we_o     (we_o),
    .stb_o    (stb_o),
    .cyc_o    (cyc_o),
    .ack_i    (ack_i),
    .dat_i    (dat_i),
    .ack_o    (bus_ack),
    .rd_dat_o (bus_rdat)
  );

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign sel_o        = '1;
  assign cti_o        = 3'b000;

endmodule

// File: tb/tb_spi_flash_fetcher.sv
// Randomized bench: behavioural SPI flash reader peripheral on Wishbone plus a
// transaction-level model of the expected register writes, polls, reads and stream.
`timescale 1ns/1ps
module tb_spi_flash_fetcher;

  localparam int          LIMIT    = 8;
  localparam logic [15:0] MEM_BASE = 16'h1000;
  localparam logic [15:0] A_CTRL   = 16'(`SPIMEM_CONTROL);
  localparam logic [15:0] A_RADDR  = 16'(`SPIMEM_READ_ADDR);
  localparam logic [15:0] A_RLEN   = 16'(`SPIMEM_READ_LENGTH);

  logic        clk, rst_i, start_i;
  logic [15:0] page_i;
  logic [8:0]  length_i;
  logic        busy_o, done_o, error_o;
  logic [15:0] adr_o;
  logic [31:0] dat_o, dat_i;
  logic        we_o, stb_o, cyc_o, ack_i;
  logic [3:0]  sel_o;
  logic [2:0]  cti_o;
  logic [31:0] word_o;
  logic        word_valid_o, word_ready_i;

  spi_flash_fetcher #(.POLL_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .page_i(page_i), .length_i(length_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .cti_o(cti_o),
    .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] adr;
    logic        we;
    logic [31:0] dat;
  } acc_t;

  acc_t        log_q[$];
  logic [31:0] stream_q[$];
  int          n_vec = 0, n_err = 0;
  int          proto_err = 0, stab_err = 0, emit_bus_err = 0, done_cnt = 0;
  logic [31:0] salt = 32'h1234_5678;
  logic [31:0] ra = '0, rl = '0;
  logic [31:0] pmem [256];
  int          busy_cnt = 0, busy_len = 3, rdy_mode = 0, stall_left = 0;
  bit          stuck = 1'b0, last_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flash_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Peripheral model: random ack latency, 3 registers, 256-word buffer.
  initial begin
    int          wait_cnt;
    bit          bus_active;
    logic [15:0] h_adr;
    logic        h_we;
    logic [31:0] h_dat, rd;
    ack_i = 1'b0; dat_i = '0; wait_cnt = 0; bus_active = 1'b0;
    h_adr = '0; h_we = 1'b0; h_dat = '0;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) busy_cnt--;
      if (sel_o !== 4'hF || cti_o !== 3'b000) proto_err++;
      if (ack_i) begin
        if (cyc_o) proto_err++;
        ack_i = 1'b0;
      end else if (cyc_o && stb_o) begin
        if (bus_active && (adr_o !== h_adr || we_o !== h_we || dat_o !== h_dat)) proto_err++;
        h_adr = adr_o; h_we = we_o; h_dat = dat_o; bus_active = 1'b1;
        if (wait_cnt == 0) begin
          if (we_o) begin
            log_q.push_back('{adr_o, 1'b1, dat_o});
            if (adr_o == A_RADDR) ra = dat_o;
            else if (adr_o == A_RLEN) rl = dat_o;
            else if (adr_o == A_CTRL && dat_o[0]) begin
              for (int i = 0; i < 256; i++)
                pmem[i] = (i < int'(rl)) ? flash_word(ra + 32'(4 * i)) : 32'hBAD0_0000 + 32'(i);
              busy_cnt = busy_len;
            end
            dat_i = '0;
          end else begin
            if (adr_o == A_CTRL) rd = {31'b0, stuck || busy_cnt != 0};
            else if (adr_o >= MEM_BASE && int'(adr_o) < int'(MEM_BASE) + 256) rd = pmem[8'(adr_o - MEM_BASE)];
            else rd = 32'hDEAD_BEEF;
            dat_i = rd;
            log_q.push_back('{adr_o, 1'b0, rd});
          end
          ack_i = 1'b1;
          bus_active = 1'b0;
          wait_cnt = $urandom_range(0, 2);
        end else begin
          wait_cnt--;
        end
      end else begin
        bus_active = 1'b0;
      end
    end
  end

  // Stream sink: ready generation, handshake capture, hold and bus-quiet checks.
  initial begin
    bit          last_valid, last_ready;
    logic [31:0] last_word;
    last_valid = 1'b0; last_ready = 1'b1; last_word = '0;
    word_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (done_o) done_cnt++;
      if (last_valid && last_ready) stream_q.push_back(last_word);
      else if (last_valid && !rst_i && (!word_valid_o || word_o !== last_word)) stab_err++;
      if (word_valid_o && cyc_o) emit_bus_err++;
      case (rdy_mode)
        1: word_ready_i = ($urandom_range(0, 3) != 0);
        2: if (word_valid_o && stream_q.size() == 2 && stall_left > 0) begin
             word_ready_i = 1'b0;
             stall_left--;
           end else begin
             word_ready_i = 1'b1;
           end
        default: word_ready_i = 1'b1;
      endcase
      last_valid = word_valid_o;
      last_word  = word_o;
      last_ready = word_ready_i;
    end
  end

  task automatic run_req(input logic [15:0] page, input logic [8:0] len, input int mode,
                         input int blen, input bit stk, input bit spurious);
    int n, k, polls, bad, cyc, exp_words;
    bit poll_bad;
    check("error_before_start", 64'(error_o), 64'(last_err));
    salt = $urandom; busy_len = blen; stuck = stk; rdy_mode = mode; stall_left = 10;
    log_q.delete(); stream_q.delete(); done_cnt = 0;
    @(negedge clk);
    start_i = 1'b1; page_i = page; length_i = len;
    @(negedge clk);
    start_i = 1'b0; page_i = 16'($urandom); length_i = 9'($urandom);
    check("error_cleared", 64'(error_o), 64'(0));
    if (len == 9'd0) begin
      check("zero_len_done", 64'(done_o), 64'(1));
      check("zero_len_busy", 64'(busy_o), 64'(0));
      @(negedge clk);
      check("zero_len_done_width", 64'(done_o), 64'(0));
      repeat (5) @(negedge clk);
      check("zero_len_bus", 64'(log_q.size()), 64'(0));
      check("zero_len_done_cnt", 64'(done_cnt), 64'(1));
      last_err = 1'b0;
      return;
    end
    check("busy_after_start", 64'(busy_o), 64'(1));
    if (spurious) begin
      repeat (3) @(negedge clk);
      start_i = 1'b1; page_i = ~page; length_i = len ^ 9'h0AA;
      @(negedge clk);
      start_i = 1'b0;
    end
    cyc = 0;
    while (!done_o && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_timeout", 64'(cyc < 20000), 64'(1));
    check("busy_at_done", 64'(busy_o), 64'(0));
    check("error_at_done", 64'(error_o), 64'(stk));
    repeat (3) @(negedge clk);
    check("done_pulses", 64'(done_cnt), 64'(1));

    n = log_q.size();
    exp_words = stk ? 0 : int'(len);
    check("log_min", 64'(n >= 4), 64'(1));
    if (n >= 4) begin
      check("wr_addr", {15'b0, log_q[0].adr, log_q[0].we, log_q[0].dat},
            {15'b0, A_RADDR, 1'b1, 8'h00, page, 8'h00});
      check("wr_len", {15'b0, log_q[1].adr, log_q[1].we, log_q[1].dat},
            {15'b0, A_RLEN, 1'b1, 23'b0, len});
      check("wr_ctrl", {15'b0, log_q[2].adr, log_q[2].we, log_q[2].dat},
            {15'b0, A_CTRL, 1'b1, 32'h1});
    end
    k = 3; polls = 0; poll_bad = 1'b0;
    while (k < n && log_q[k].adr == A_CTRL && !log_q[k].we) begin
      polls++;
      if (k + 1 < n && log_q[k + 1].adr == A_CTRL && log_q[k].dat[0] == 1'b0) poll_bad = 1'b1;
      k++;
    end
    if (stk) check("poll_count_timeout", 64'(polls), 64'(LIMIT));
    else     check("poll_count_range", 64'(polls >= 1 && polls <= LIMIT), 64'(1));
    check("poll_sequence", 64'(poll_bad), 64'(0));
    bad = 0;
    for (int i = 0; i < exp_words; i++)
      if (k + i >= n || log_q[k + i].we || log_q[k + i].adr != MEM_BASE + 16'(i)) bad++;
    check("mem_reads_bad", 64'(bad), 64'(0));
    check("bus_access_count", 64'(n), 64'(3 + polls + exp_words));
    check("stream_len", 64'(stream_q.size()), 64'(exp_words));
    bad = 0;
    for (int i = 0; i < exp_words; i++)
      if (i >= stream_q.size() || stream_q[i] !== flash_word({8'h00, page, 8'h00} + 32'(4 * i))) bad++;
    check("stream_data_bad", 64'(bad), 64'(0));
    last_err = stk;
  endtask

  task automatic reset_mid_poll();
    int cyc;
    bit seen;
    salt = $urandom; busy_len = 0; stuck = 1'b1; rdy_mode = 0;
    log_q.delete(); stream_q.delete(); done_cnt = 0;
    @(negedge clk);
    start_i = 1'b1; page_i = 16'h0055; length_i = 9'd5;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 500) begin
      @(negedge clk);
      cyc++;
      foreach (log_q[i]) if (log_q[i].adr == A_CTRL && !log_q[i].we) seen = 1'b1;
    end
    check("reached_poll", 64'(seen), 64'(1));
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_cyc", 64'(cyc_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    rst_i = 1'b0;
    stuck = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_done", 64'(done_cnt), 64'(0));
    check("rst_idle_bus", 64'(cyc_o), 64'(0));
    last_err = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; page_i = '0; length_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy_o, done_o, error_o, we_o, stb_o, cyc_o, word_valid_o, cti_o},
          {7'b0, 3'b000});
    check("reset_sel", 64'(sel_o), 64'(4'hF));
    check("reset_buses", {adr_o, dat_o}, 64'(0));
    check("reset_word", 64'(word_o), 64'(0));
    rst_i = 1'b0;
    @(negedge clk);

    run_req(16'h0012, 9'd4, 0, 3, 1'b0, 1'b0);
    run_req(16'h0012, 9'd4, 2, 3, 1'b0, 1'b0);
    run_req(16'hBEEF, 9'd256, 1, 5, 1'b0, 1'b0);
    run_req(16'h0007, 9'd0, 0, 3, 1'b0, 1'b0);
    run_req(16'h0345, 9'd6, 0, 3, 1'b1, 1'b0);
    run_req(16'h0345, 9'd3, 0, 3, 1'b0, 1'b1);
    reset_mid_poll();
    run_req(16'h00AA, 9'd5, 0, 3, 1'b0, 1'b0);
    for (int t = 0; t < 12; t++)
      run_req(16'($urandom), 9'($urandom_range(1, 24)), $urandom_range(0, 2),
              $urandom_range(1, 20), 1'b0, 1'($urandom_range(0, 1)));

    check("bus_protocol_errors", 64'(proto_err), 64'(0));
    check("stream_hold_errors", 64'(stab_err), 64'(0));
    check("bus_during_emit", 64'(emit_bus_err), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
